// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - shared binary32 field layout, constants and requester id type
package fp_mul_pkg;

  localparam int FP_W     = 32;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int EXP_BIAS = 127;
  localparam logic [FP_W-1:0] QNAN = 32'h7FC00000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  typedef logic req_id_t;

endpackage

// File: rtl/FP_Multiplier_Single_Hybrid_Booth.sv
// rtl/FP_Multiplier_Single_Hybrid_Booth.sv - combinational binary32 multiplier core, round-to-nearest-even
module FP_Multiplier_Single_Hybrid_Booth (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p
);
  import fp_mul_pkg::*;

  fp32_t              fa, fb;
  logic               sign;
  logic [23:0]        ma, mb;
  logic [47:0]        prod;
  logic signed [9:0]  e;
  logic [22:0]        mant;
  logic               g, st;
  logic [23:0]        rnd;

  assign fa   = a;
  assign fb   = b;
  assign sign = fa.sign ^ fb.sign;
  // Hidden bit is only present for normal operands; denormals fall out as near-zero products.
  assign ma   = {|fa.exp, fa.man};
  assign mb   = {|fb.exp, fb.man};
  assign prod = ma * mb;

  // Normalise the 48-bit product, round to nearest even, then saturate to inf or flush to zero.
  always_comb begin
    e = 10'(fa.exp) + 10'(fb.exp) - 10'(EXP_BIAS);
    if (prod[47]) begin
      mant = prod[46:24];
      g    = prod[23];
      st   = |prod[22:0];
      e    = e + 10'sd1;
    end else begin
      mant = prod[45:23];
      g    = prod[22];
      st   = |prod[21:0];
    end
    rnd = {1'b0, mant} + {23'd0, g & (st | mant[0])};
    if (rnd[23]) e = e + 10'sd1;
    if (prod == 48'd0 || e <= 10'sd0) p = {sign, 31'd0};
    else if (e >= 10'sd255)           p = {sign, 8'hFF, 23'd0};
    else                              p = {sign, e[7:0], rnd[22:0]};
  end

endmodule

// File: rtl/fp_mul_special_case.sv
// rtl/fp_mul_special_case.sv - classifies operands and overrides the core product for NaN/Inf/zero
module fp_mul_special_case (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] core_p,
  output logic [31:0] p
);
  import fp_mul_pkg::*;

  fp32_t fa, fb;
  logic  sign;
  logic  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign fa     = a;
  assign fb     = b;
  assign sign   = fa.sign ^ fb.sign;
  assign a_nan  = (&fa.exp) && (|fa.man);
  assign b_nan  = (&fb.exp) && (|fb.man);
  assign a_inf  = (&fa.exp) && !(|fa.man);
  assign b_inf  = (&fb.exp) && !(|fb.man);
  // Denormals are treated as zero, so Inf x denormal also yields NaN.
  assign a_zero = !(|fa.exp);
  assign b_zero = !(|fb.exp);

  // Priority: NaN sources first, then infinities, then zeros, else trust the core.
  always_comb begin
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      p = QNAN;
    else if (a_inf || b_inf)
      p = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (a_zero || b_zero)
      p = {sign, {(EXP_W+MAN_W){1'b0}}};
    else
      p = core_p;
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - round-robin sharing of one binary32 multiplier, two-stage pipeline (FPMUL_SPECIAL_CASE_EN adds special-operand override)
module fp_mul_arbiter #(
  parameter int FP_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [FP_W-1:0] req0_a,
  input  logic [FP_W-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [FP_W-1:0] req1_a,
  input  logic [FP_W-1:0] req1_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_id,
  output logic [FP_W-1:0] out_p
);
  import fp_mul_pkg::*;

  logic            s1_valid;
  req_id_t         s1_id;
  logic [FP_W-1:0] s1_a, s1_b;
  logic            prio;
  logic            adv, grant0, grant1;
  logic [FP_W-1:0] core_p, s2_load;

  // Whole pipeline moves together whenever the output slot is free or being drained.
  assign adv    = !out_valid || out_ready;
  assign grant0 = req0_valid && (!req1_valid || !prio);
  assign grant1 = req1_valid && (!req0_valid || prio);
  assign req0_ready = rst_n && adv && grant0;
  assign req1_ready = rst_n && adv && grant1;

  FP_Multiplier_Single_Hybrid_Booth u_core (
    .a (s1_a),
    .b (s1_b),
    .p (core_p)
  );

`ifdef FPMUL_SPECIAL_CASE_EN
  fp_mul_special_case u_special (
    .a      (s1_a),
    .b      (s1_b),
    .core_p (core_p),
    .p      (s2_load)
  );
`else
  assign s2_load = core_p;
`endif

  // Operand stage, result stage and round-robin pointer all update on the shared advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_id     <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      out_valid <= 1'b0;
      out_id    <= 1'b0;
      out_p     <= '0;
      prio      <= 1'b0;
    end else if (adv) begin
      s1_valid  <= grant0 || grant1;
      s1_id     <= grant1;
      s1_a      <= grant1 ? req1_a : req0_a;
      s1_b      <= grant1 ? req1_b : req0_b;
      out_valid <= s1_valid;
      out_id    <= s1_id;
      out_p     <= s2_load;
      if (grant0 || grant1) prio <= grant0;
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb/tb_fp_mul_arbiter.sv - self-checking bench: directed cases plus randomized traffic against a real-arithmetic model
module tb_fp_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        out_valid, out_ready, out_id;
  logic [31:0] out_p;

  always #5 clk = ~clk;

  fp_mul_arbiter #(.FP_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_id     (out_id),
    .out_p      (out_p)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic real to_real(input logic [31:0] x);
    real m = 1.0 + real'(x[22:0]) / 8388608.0;
    real v = m * (2.0 ** (real'(x[30:23]) - 127.0));
    return x[31] ? -v : v;
  endfunction

  function automatic logic [31:0] to_f32(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (r == 0.0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
`ifdef FPMUL_SPECIAL_CASE_EN
    logic s  = a[31] ^ b[31];
    logic an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    logic bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    logic ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    logic bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    logic az = (a[30:23] == 8'h00);
    logic bz = (b[30:23] == 8'h00);
    if (an || bn || (ai && bz) || (bi && az)) return 32'h7FC00000;
    if (ai || bi) return {s, 8'hFF, 23'd0};
    if (az || bz) return {s, 31'd0};
`endif
    return to_f32(to_real(a) * to_real(b));
  endfunction

  // Random operand: up to 12 significant bits so every product is exact in binary32.
  function automatic logic [31:0] rand_op();
    real v = real'($urandom_range(1, 4095)) * (2.0 ** (real'($urandom_range(0, 16)) - 8.0));
    if ($urandom_range(0, 1) == 1) v = -v;
    return to_f32(v);
  endfunction

  logic        m_s1_v, m_s1_id, m_out_v, m_out_id, m_adv;
  logic [31:0] m_s1_p, m_out_p;
  int          last_win, winner, acc_cnt, del_cnt;
  int          grant_log[$];
  logic        hs0, hs1, pend0, pend1;
  logic [31:0] pa0, pb0, pa1, pb1;
  logic        want0, want1, rnd_mode;

  // Reference: last-winner round robin feeding a two-slot in-order pipeline, checked every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ready0", 32'(req0_ready), 32'd0);
      check("rst_ready1", 32'(req1_ready), 32'd0);
      m_s1_v = 0; m_out_v = 0; last_win = 1;
      hs0 = 0; hs1 = 0; pend0 = 0; pend1 = 0;
      acc_cnt = 0; del_cnt = 0;
    end else begin
      check("out_valid", 32'(out_valid), 32'(m_out_v));
      if (m_out_v) begin
        check("out_id", 32'(out_id), 32'(m_out_id));
        check("out_p", out_p, m_out_p);
      end
      if (pend0) begin
        check("hold_req0", 32'(req0_valid), 32'd1);
        check("hold_ops0", (req0_a ^ pa0) | (req0_b ^ pb0), 32'd0);
      end
      if (pend1) begin
        check("hold_req1", 32'(req1_valid), 32'd1);
        check("hold_ops1", (req1_a ^ pa1) | (req1_b ^ pb1), 32'd0);
      end
      m_adv = !m_out_v || out_ready;
      winner = -1;
      if (req0_valid && req1_valid) winner = (last_win == 0) ? 1 : 0;
      else if (req0_valid)          winner = 0;
      else if (req1_valid)          winner = 1;
      if (!m_adv) winner = -1;
      check("ready0", 32'(req0_ready), 32'(winner == 0));
      check("ready1", 32'(req1_ready), 32'(winner == 1));
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      if (hs0 || hs1) acc_cnt++;
      if (out_valid && out_ready) del_cnt++;
      pend0 = req0_valid && !req0_ready; pa0 = req0_a; pb0 = req0_b;
      pend1 = req1_valid && !req1_ready; pa1 = req1_a; pb1 = req1_b;
      if (m_adv) begin
        m_out_v = m_s1_v; m_out_id = m_s1_id; m_out_p = m_s1_p;
        m_s1_v = (winner >= 0);
        if (winner >= 0) begin
          m_s1_id = winner[0];
          m_s1_p  = (winner == 1) ? model_mul(req1_a, req1_b) : model_mul(req0_a, req0_b);
          last_win = winner;
          grant_log.push_back(winner);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (hs0) req0_valid = 1'b0;
    if (hs1) req1_valid = 1'b0;
    if (rnd_mode) begin
      if (!req0_valid && $urandom_range(0, 3) != 0) begin
        req0_valid = 1'b1; req0_a = rand_op(); req0_b = rand_op();
      end
      if (!req1_valid && $urandom_range(0, 3) != 0) begin
        req1_valid = 1'b1; req1_a = rand_op(); req1_b = rand_op();
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      if (want0) req0_valid = 1'b1;
      if (want1) req1_valid = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    req0_valid = 0; req1_valid = 0; out_ready = 1;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    want0 = 0; want1 = 0; rnd_mode = 0;
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_p", out_p, 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    rst_n = 1'b1;

    // Single requester, exact latency
    req0_a = 32'hC1900000; req0_b = 32'hC1180000; req0_valid = 1;
    @(negedge clk);
    check("t1_ready", 32'(req0_ready), 32'd1);
    tick();
    check("t1_lat_n", 32'(out_valid), 32'd0);
    tick();
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_p", out_p, 32'h432B0000);
    check("t1_id", 32'(out_id), 32'd0);
    tick();

    // Continuous dual requests alternate from prio=0
    do_reset();
    req0_a = 32'hC1A00000; req0_b = 32'h42200000;
    req1_a = 32'hC1900000; req1_b = 32'hC1180000;
    grant_log.delete();
    want0 = 1; want1 = 1; req0_valid = 1; req1_valid = 1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i >= 2) begin
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_p", out_p, (i % 2 == 0) ? 32'hC4480000 : 32'h432B0000);
        check("t2_id", 32'(out_id), (i % 2 == 0) ? 32'd0 : 32'd1);
      end
    end
    for (int i = 0; i < 4; i++)
      check("t2_grant", 32'((i < grant_log.size()) ? grant_log[i] : -1), 32'(i % 2));
    want0 = 0; want1 = 0;
    repeat (4) tick();

    // Stall with both stages full and a pending request
    do_reset();
    out_ready = 0; req0_valid = 1; req1_valid = 1;
    tick(); tick();
    req0_valid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_valid", 32'(out_valid), 32'd1);
      check("t3_p", out_p, 32'hC4480000);
      check("t3_id", 32'(out_id), 32'd0);
      check("t3_ready0", 32'(req0_ready), 32'd0);
      check("t3_ready1", 32'(req1_ready), 32'd0);
    end
    out_ready = 1;
    tick();
    check("t3_drain1_p", out_p, 32'h432B0000);
    check("t3_drain1_id", 32'(out_id), 32'd1);
    tick();
    check("t3_drain2_v", 32'(out_valid), 32'd1);
    check("t3_drain2_p", out_p, 32'hC4480000);
    tick();
    check("t3_empty", 32'(out_valid), 32'd0);

    // Reset with both stages full discards everything
    out_ready = 0; req0_valid = 1; req1_valid = 1;
    tick(); tick();
    rst_n = 0;
    tick();
    check("t4_valid", 32'(out_valid), 32'd0);
    check("t4_p", out_p, 32'd0);
    rst_n = 1; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_no_stale", 32'(out_valid), 32'd0);
    end
    grant_log.delete();
    req0_valid = 1; req1_valid = 1;
    tick();
    check("t4_first_grant", 32'((grant_log.size() > 0) ? grant_log[0] : -1), 32'd0);
    repeat (4) tick();

`ifdef FPMUL_SPECIAL_CASE_EN
    req0_a = 32'h7F800000; req0_b = 32'h00000000; req0_valid = 1;
    tick(); tick();
    check("sc_inf_zero", out_p, 32'h7FC00000);
    req0_a = 32'hFF800000; req0_b = 32'h40000000; req0_valid = 1;
    tick(); tick();
    check("sc_inf_fin", out_p, 32'hFF800000);
    req0_a = 32'h80000000; req0_b = 32'h42200000; req0_valid = 1;
    tick(); tick();
    check("sc_zero", out_p, 32'h80000000);
    tick();
`endif

    // Randomized traffic and backpressure
    rnd_mode = 1;
    repeat (10000) tick();
    rnd_mode = 0; out_ready = 1;
    repeat (10) tick();
    check("rand_no_loss", 32'(del_cnt), 32'(acc_cnt));
    check("rand_drained", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
